// File: rtl/linear_layer_q_fifo_srl_ctrl.sv
// Shift-register FIFO with push/pop control, occupancy count and registered
// full/empty flags, used as the default stream channel between the
// quantize and compute stages. First-word fall-through on if_dout.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   if_write_ce/if_write: producer write enable / request, if_din data
//   if_full_n           : registered, 1 = space available
//   if_read_ce/if_read  : consumer read enable / pop request
//   if_dout             : oldest stored word
//   if_empty_n          : registered, 1 = if_dout valid
//   if_num_data_valid   : registered occupancy 0..DEPTH
//   if_fifo_cap         : constant DEPTH
module linear_layer_q_fifo_srl_ctrl #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 2,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   if_num_data_valid,
   output logic [ADDR_WIDTH:0]   if_fifo_cap
);

   localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] entry [DEPTH];
   logic [ADDR_WIDTH:0]   count;
   logic [ADDR_WIDTH:0]   cnt_inc;
   logic [ADDR_WIDTH:0]   cnt_dec;
   logic [ADDR_WIDTH-1:0] raddr;
   logic                  full_n;
   logic                  empty_n;
   logic                  push;
   logic                  pop;

   assign push    = if_write & if_write_ce & full_n;
   assign pop     = if_read & if_read_ce & empty_n;
   assign cnt_inc = count + 1'b1;
   assign cnt_dec = count - 1'b1;

   // Newest word sits at entry[0], so the oldest is at count-1.
   assign raddr = (count != '0) ? cnt_dec[ADDR_WIDTH-1:0] : '0;

   always_comb begin
      if_dout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr == ADDR_WIDTH'(i)) begin
            if_dout = entry[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry[i] <= '0;
         end
      end else if (push) begin
         for (int i = 1; i < DEPTH; i++) begin
            entry[i] <= entry[i-1];
         end
         entry[0] <= if_din;
      end
   end

   // On simultaneous push and pop the shift moves the next-older word
   // into the unchanged read address, so count and flags just hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         full_n  <= 1'b1;
         empty_n <= 1'b0;
      end else if (push && !pop) begin
         count   <= cnt_inc;
         empty_n <= 1'b1;
         full_n  <= (cnt_inc != CAP);
      end else if (pop && !push) begin
         count   <= cnt_dec;
         full_n  <= 1'b1;
         empty_n <= (cnt_dec != '0);
      end
   end

   assign if_full_n         = full_n;
   assign if_empty_n        = empty_n;
   assign if_num_data_valid = count;
   assign if_fifo_cap       = CAP;

endmodule

// File: tb/tb_linear_layer_q_fifo_srl_ctrl.sv
// Scoreboard bench for linear_layer_q_fifo_srl_ctrl at default parameters.
// A queue model tracks accepted words; pops are compared against it.
module tb_linear_layer_q_fifo_srl_ctrl;
   localparam int DW = 128;
   localparam int AW = 2;
   localparam int D  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_write_ce;
   logic          if_write;
   logic [DW-1:0] if_din;
   logic          if_full_n;
   logic          if_read_ce;
   logic          if_read;
   logic [DW-1:0] if_dout;
   logic          if_empty_n;
   logic [AW:0]   if_num_data_valid;
   logic [AW:0]   if_fifo_cap;

   linear_layer_q_fifo_srl_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)
   ) dut (
      .clk(clk), .reset(reset),
      .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
      .if_full_n(if_full_n),
      .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
      .if_empty_n(if_empty_n),
      .if_num_data_valid(if_num_data_valid), .if_fifo_cap(if_fifo_cap)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] q[$];
   int total = 0;
   int bad = 0;
   bit zero_store = 1'b1;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ":cnt"}, DW'(if_num_data_valid), DW'(q.size()));
      chk({tag, ":empty_n"}, DW'(if_empty_n), DW'(q.size() != 0));
      chk({tag, ":full_n"}, DW'(if_full_n), DW'(q.size() != D));
      if (q.size() > 0)
         chk({tag, ":dout"}, if_dout, q[0]);
      else if (zero_store)
         chk({tag, ":dout0"}, if_dout, '0);
   endtask

   task automatic cyc(input bit wr, input logic [DW-1:0] d, input bit rd,
                      input bit wce, input bit rce, input string tag);
      bit push;
      bit pop;
      if_write    = wr;
      if_din      = d;
      if_read     = rd;
      if_write_ce = wce;
      if_read_ce  = rce;
      push = !reset && wr && wce && (q.size() < D);
      pop  = !reset && rd && rce && (q.size() > 0);
      if (pop)
         chk({tag, ":pop"}, if_dout, q[0]);
      @(posedge clk);
      #1;
      if (reset) begin
         q.delete();
         zero_store = 1'b1;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(d);
            zero_store = 1'b0;
         end
      end
      if_write = 1'b0;
      if_read  = 1'b0;
      check_state(tag);
   endtask

   initial begin
      reset = 1'b1;
      if_write_ce = 1'b1;
      if_read_ce  = 1'b1;
      if_write = 1'b0;
      if_read  = 1'b0;
      if_din   = '0;
      #2;
      cyc(0, '0, 0, 1, 1, "rst");
      reset = 1'b0;
      repeat (5) cyc(0, '0, 0, 1, 1, "idle");
      chk("cap", DW'(if_fifo_cap), DW'(2));

      cyc(1, 'hA, 0, 1, 1, "pushA");
      chk("pushA_dout", if_dout, 'hA);
      cyc(1, 'hB, 0, 1, 1, "pushB");
      chk("pushB_full_n", DW'(if_full_n), '0);
      cyc(1, 'hC, 0, 1, 1, "pushC_full");
      chk("pushC_cnt", DW'(if_num_data_valid), DW'(2));

      cyc(1, 'hC, 1, 1, 1, "pp_full");
      chk("pp_full_dout", if_dout, 'hB);
      chk("pp_full_cnt", DW'(if_num_data_valid), DW'(1));
      cyc(1, 'hC, 0, 1, 1, "pushC2");
      chk("pushC2_dout", if_dout, 'hB);

      cyc(0, '0, 1, 1, 1, "to_one");
      for (int i = 0; i < 100; i++) begin
         cyc(1, DW'(32'h100 + i), 1, 1, 1, "stream");
      end
      chk("stream_last", if_dout, DW'(32'h100 + 99));

      cyc(0, '0, 1, 1, 1, "drain");
      cyc(1, 'h5, 1, 1, 1, "nobypass");
      chk("nobypass_dout", if_dout, 'h5);
      chk("nobypass_cnt", DW'(if_num_data_valid), DW'(1));
      cyc(0, '0, 1, 1, 1, "drain2");
      cyc(1, 'h5, 1, 0, 1, "wce0");
      chk("wce0_cnt", DW'(if_num_data_valid), '0);
      cyc(1, 'h7, 0, 1, 0, "rce0_push");
      cyc(0, '0, 1, 1, 0, "rce0_pop");
      chk("rce0_dout", if_dout, 'h7);

      cyc(1, 'h22, 0, 1, 1, "fill");
      reset = 1'b1;
      cyc(1, 'h33, 0, 1, 1, "rst_mid");
      reset = 1'b0;
      chk("rst_mid_dout", if_dout, '0);
      chk("rst_mid_empty", DW'(if_empty_n), '0);
      cyc(0, '0, 0, 1, 1, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
